// File: rtl/cap_scan_pkg.sv
// Shared FSM encoding and default sizing for the capacitive sensor scanner.
package cap_scan_pkg;

    localparam int CNT_W_DEFAULT        = 16;
    localparam int DISCH_CYCLES_DEFAULT = 5000;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DISCHARGE = 2'd1;
    localparam logic [1:0] ST_MEASURE   = 2'd2;
    localparam logic [1:0] ST_RESULT    = 2'd3;

endpackage

// File: rtl/cap_touch_debounce.sv
// Per-channel touch debounce: the flag changes only after two matching results in a row.
module cap_touch_debounce
    import cap_scan_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic update,
    input  logic above,
    output logic touch
);

    logic last_above;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_above <= 1'b0;
            touch      <= 1'b0;
        end else if (update) begin
            last_above <= above;
            if (above && last_above)
                touch <= 1'b1;
            else if (!above && !last_above)
                touch <= 1'b0;
        end
    end

endmodule

// File: rtl/cap_sensor_scanner.sv
// Round-robin capacitive touch scanner measuring pad rise time per channel.
// Define CAP_SCAN_DEBOUNCE_EN to debounce each touch flag over two results.
module cap_sensor_scanner
    import cap_scan_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int CNT_W        = CNT_W_DEFAULT,
    parameter int DISCH_CYCLES = DISCH_CYCLES_DEFAULT,
    parameter int TIMEOUT      = 2**CNT_W - 1
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     enable,
    input  logic [CNT_W-1:0]         threshold,
    input  logic [N_CH-1:0]          sensor_in,
    output logic [N_CH-1:0]          sensor_out,
    output logic [CNT_W-1:0]         count_out,
    output logic [$clog2(N_CH)-1:0]  count_ch,
    output logic                     count_valid,
    output logic [N_CH-1:0]          touch,
    output logic                     scan_done
);

    localparam int CH_W = $clog2(N_CH);
    localparam int DW   = $clog2(DISCH_CYCLES + 1);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(N_CH - 1);
    localparam logic [DW-1:0]    DISCH_LAST = DW'(DISCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

    logic [1:0]       state;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] counter;
    logic [DW-1:0]    disch_cnt;
    logic [N_CH-1:0]  sync_meta;
    logic [N_CH-1:0]  sync_q;
    logic             result_above;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= sensor_in;
            sync_q    <= sync_meta;
        end
    end

    // Dropping enable outside RESULT abandons the measurement without reporting it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            ch          <= '0;
            counter     <= '0;
            disch_cnt   <= '0;
            count_out   <= '0;
            count_ch    <= '0;
            count_valid <= 1'b0;
            scan_done   <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            scan_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ch <= '0;
                    if (enable) begin
                        state     <= ST_DISCHARGE;
                        disch_cnt <= '0;
                    end
                end
                ST_DISCHARGE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (disch_cnt == DISCH_LAST) begin
                        state   <= ST_MEASURE;
                        counter <= '0;
                    end else begin
                        disch_cnt <= disch_cnt + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (!enable)
                        state <= ST_IDLE;
                    else if (sync_q[ch] || counter == TIMEOUT_C)
                        state <= ST_RESULT;
                    else
                        counter <= counter + 1'b1;
                end
                ST_RESULT: begin
                    count_out   <= counter;
                    count_ch    <= ch;
                    count_valid <= 1'b1;
                    disch_cnt   <= '0;
                    if (ch != LAST_CH) begin
                        ch    <= ch + 1'b1;
                        state <= ST_DISCHARGE;
                    end else begin
                        scan_done <= 1'b1;
                        ch        <= '0;
                        state     <= enable ? ST_DISCHARGE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sensor_out = '0;
        if (state == ST_MEASURE)
            sensor_out[ch] = 1'b1;
    end

    assign result_above = (counter > threshold);

`ifdef CAP_SCAN_DEBOUNCE_EN
    for (genvar i = 0; i < N_CH; i++) begin : g_debounce
        cap_touch_debounce u_debounce (
            .clock  (clock),
            .resetn (resetn),
            .update ((state == ST_RESULT) && (ch == CH_W'(i))),
            .above  (result_above),
            .touch  (touch[i])
        );
    end
`else
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            touch <= '0;
        else if (state == ST_RESULT)
            touch[ch] <= result_above;
    end
`endif

endmodule
